oled_text_streamer: RTL
=======================

// Module: oled_text_streamer
// PURPOSE
//  Receiving end of the processor-to-display character write port (we / 6-bit addr / 8-bit data).
//  Holds a 64-byte text buffer and streams it to the OLED over a write-only SPI link (mode 0).
//  Each frame is 2 command bytes (dc=0) followed by buffer[0..63] (dc=1).
//  Sits between the processor top level and the OLED pins.
// PARAMETERS
//  CLK_DIV  4      sysclk cycles per sclk half-period; legal range 1..255
//  CMD0     8'h20  first header byte, sent with dc=0
//  CMD1     8'h00  second header byte, sent with dc=0
// PORTS
//  sysclk         in   1  system clock; all logic on posedge
//  rst            in   1  synchronous reset, active-high
//  we_ip          in   1  buffer write strobe
//  write_addr_ip  in   6  buffer index for the write
//  write_data_ip  in   8  byte written to buffer[write_addr_ip]
//  refresh_ip     in   1  request a frame even when no write has occurred
//  busy_op        out  1  high while a frame is being sent
//  frame_done_op  out  1  1-cycle pulse when a frame completes
//  oled_sclk      out  1  SPI clock; idles low
//  oled_sdin      out  1  SPI data, MSB first
//  oled_dc        out  1  0 = command byte, 1 = data byte
// BEHAVIOUR
//  Reset (rst=1 at posedge), applied even mid-frame; the frame is abandoned at once:
//   - all 64 buffer bytes <= 8'h20; dirty <= 1; FSM <= IDLE
//   - busy_op, frame_done_op, oled_sclk, oled_sdin, oled_dc all <= 0
//   - so the first frame after reset sends blanks.
//  Buffer:
//   - we_ip=1 writes write_data_ip into buffer[write_addr_ip] at the posedge and sets dirty.
//   - refresh_ip=1 sets dirty.
//   - Writes are accepted in every state and never stall.
//  FSM states: IDLE, LOAD, SHIFT.
//   - IDLE: if dirty, clear dirty and go to LOAD with byte index 0.
//     dirty set in the same cycle it is cleared stays set, so the request is not lost.
//   - LOAD (1 cycle): load the next byte into the shift register.
//     - index 0 -> CMD0, index 1 -> CMD1, both with dc=0.
//     - index k (2..65) -> buffer[k-2] as sampled at this edge, with dc=1.
//     - A write to the same address in the same cycle is not seen (read-before-write).
//     - sdin <= bit7, sclk stays 0, go to SHIFT.
//   - SHIFT: 8 bits, each CLK_DIV cycles sclk=0 then CLK_DIV cycles sclk=1.
//     - sdin changes only on the edge where sclk falls (or on LOAD), so it is stable across each rising sclk.
//     - After bit0's high phase: sclk <= 0; if index<65, index++ and go to LOAD; else go to IDLE.
//   - On the IDLE return, frame_done_op pulses for 1 cycle.
//  Timing:
//   - Each byte takes 1+16*CLK_DIV cycles; a frame takes 66*(1+16*CLK_DIV) cycles (4290 at CLK_DIV=4).
//   - busy_op=1 from the first LOAD cycle through the last SHIFT cycle; 0 in IDLE.
//  Writes during a frame:
//   - Bytes not yet loaded carry the new value.
//   - dirty is set again, so a second full frame starts 1 cycle after frame_done_op.
//  oled_dc changes only in LOAD, and holds through all 8 bits of its byte.
//  Byte and bit counters saturate at their terminal states; they do not wrap.
// TESTING
//  - Reset release, no input: frame starts; SPI capture = 20 00 then 64x 20.
//    frame_done_op pulses once, 4290 cycles after busy_op rises; then idle, no second frame.
//  - Write addr 0 = 8'h48 and addr 63 = 8'h21 while idle:
//    next frame data byte0 = 48, byte63 = 21; dc=0 on the 2 header bytes only.
//  - Write addr 10 = 8'h41 during header byte 1:
//    the current frame already carries 41 at data byte10; a second identical frame follows, then idle.
//  - Write addr 5 in the cycle LOAD samples index 7 (buffer[5]):
//    old value is sent; the next frame sends the new value.
//  - Assert rst mid-SHIFT of data byte 30:
//    all outputs 0 next cycle; the new frame is all 20 bytes.
//  - CLK_DIV=1: sclk period 2 cycles; 17 cycles per byte.
//    sdin is never sampled changing at a rising sclk (SVA).

Source files
------------

// File: rtl/oled_text_streamer.sv
`default_nettype none
// ============================================================================
// Module      : oled_text_streamer
// Description : Holds a 64-byte text buffer written by the processor and
//               streams it to an OLED over a write-only SPI link (mode 0).
//               Each frame is CMD0, CMD1 (dc=0) followed by buffer[0..63]
//               (dc=1), MSB first.
// Ports       : sysclk        - system clock, all logic on posedge
//               rst           - synchronous active-high reset
//               we_ip         - buffer write strobe
//               write_addr_ip - buffer index for the write (6 bits)
//               write_data_ip - byte written to buffer[write_addr_ip]
//               refresh_ip    - request a frame without a write
//               busy_op       - high while a frame is being sent
//               frame_done_op - one-cycle pulse when a frame completes
//               oled_sclk     - SPI clock, idles low
//               oled_sdin     - SPI data, MSB first
//               oled_dc       - 0 = command byte, 1 = data byte
// Revision    : 1.0 - initial release
// ============================================================================
module oled_text_streamer #(
    parameter int         CLK_DIV = 4,
    parameter logic [7:0] CMD0    = 8'h20,
    parameter logic [7:0] CMD1    = 8'h00
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       we_ip,
    input  logic [5:0] write_addr_ip,
    input  logic [7:0] write_data_ip,
    input  logic       refresh_ip,
    output logic       busy_op,
    output logic       frame_done_op,
    output logic       oled_sclk,
    output logic       oled_sdin,
    output logic       oled_dc
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [6:0] c_LAST_IDX = 7'd65;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_buf [0:63];
    logic       r_dirty;
    logic [6:0] r_idx;       // 0,1 = header bytes; 2..65 = buffer[idx-2]
    logic [2:0] r_bit;       // bits remaining after the current one
    logic [7:0] r_div;       // cycles spent in the current sclk half-period
    logic [7:0] r_shift;     // bit 7 drives oled_sdin
    logic       r_busy;
    logic       r_done;
    logic       r_sclk;
    logic       r_dc;

    logic       w_div_end;
    logic       w_clr_dirty;
    logic [5:0] w_buf_addr;
    logic [7:0] w_load_byte;

    assign w_div_end  = (r_div == c_DIV_LAST);
    assign w_buf_addr = 6'(r_idx - 7'd2);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_clr_dirty = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_dirty) begin
                    w_clr_dirty = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // End of bit0's high phase closes the byte.
                if (w_div_end && r_sclk && (r_bit == 3'd0)) begin
                    w_state_nxt = (r_idx < c_LAST_IDX) ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte presented to the shift register on a LOAD cycle. The buffer read
    // uses the registered contents, so a same-cycle write is not seen.
    always_comb begin
        w_load_byte = r_buf[w_buf_addr];
        if (r_idx == 7'd0) begin
            w_load_byte = CMD0;
        end else if (r_idx == 7'd1) begin
            w_load_byte = CMD1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Text buffer and frame request flag
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                r_buf[i] <= 8'h20;
            end
        end else if (we_ip) begin
            r_buf[write_addr_ip] <= write_data_ip;
        end
    end

    // A new request wins over the clear so a write landing on the frame
    // start edge still produces a following frame.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_dirty <= 1'b1;
        end else if (we_ip || refresh_ip) begin
            r_dirty <= 1'b1;
        end else if (w_clr_dirty) begin
            r_dirty <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser datapath
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_idx   <= 7'd0;
            r_bit   <= 3'd0;
            r_div   <= 8'd0;
            r_shift <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_dc    <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (r_state == S_SHIFT) && (w_state_nxt == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (r_dirty) begin
                        r_idx <= 7'd0;
                    end
                end
                S_LOAD: begin
                    r_shift <= w_load_byte;
                    r_dc    <= (r_idx >= 7'd2);
                    r_sclk  <= 1'b0;
                    r_div   <= 8'd0;
                    r_bit   <= 3'd7;
                end
                S_SHIFT: begin
                    if (!w_div_end) begin
                        r_div <= r_div + 8'd1;
                    end else begin
                        r_div <= 8'd0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // Falling sclk: the only point inside a byte where
                            // sdin moves on to the next bit.
                            r_sclk <= 1'b0;
                            if (r_bit != 3'd0) begin
                                r_bit   <= r_bit - 3'd1;
                                r_shift <= {r_shift[6:0], 1'b0};
                            end else if (r_idx < c_LAST_IDX) begin
                                r_idx <= r_idx + 7'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_sclk <= 1'b0;
                end
            endcase
        end
    end

    assign busy_op       = r_busy;
    assign frame_done_op = r_done;
    assign oled_sclk     = r_sclk;
    assign oled_sdin     = r_shift[7];
    assign oled_dc       = r_dc;

endmodule
`default_nettype wire
